// File: rtl/ir_seq_pkg.sv
// ir_seq_pkg: state encoding and ROM header field layout shared by the IR sequencer.
package ir_seq_pkg;
   typedef enum logic [3:0] {IDLE, HDR, MARK_RD, MARK, SPACE_RD, SPACE, GAP, END, FAIL} state_t;
   localparam int CARRIER_MSB = 15;
   localparam int CARRIER_LSB = 8;
   localparam int PAIRS_MSB = 7;
   localparam logic [7:0] END_MARKER = 8'h00;
endpackage

// File: rtl/ir_code_sequencer_if.sv
// ir_code_sequencer_if: synchronous code-table ROM read port.
interface ir_code_sequencer_if #(parameter int ADDR_W = 10) ();
   logic              rom_en;
   logic [ADDR_W-1:0] rom_addr;
   logic [15:0]       rom_data;
   modport master (output rom_en, rom_addr, input rom_data);
   modport slave (input rom_en, rom_addr, output rom_data);
endinterface

// File: rtl/ir_carrier_gen.sv
// ir_carrier_gen: square-wave carrier, high on the first enabled cycle, toggling every half_period clocks.
module ir_carrier_gen (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [7:0] half_period,
   output logic       carrier
);
   logic       car_q, car_d, on_q, on_d, flip;
   logic [7:0] cnt_q, cnt_d;
   always_comb begin
      flip = on_q && cnt_q == half_period - 8'd1;
      car_d = en && (on_q ? car_q ^ flip : 1'b1);
      cnt_d = (en && on_q && !flip) ? cnt_q + 8'd1 : 8'd0;
      on_d = en;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         car_q <= 1'b0;
         on_q <= 1'b0;
         cnt_q <= 8'd0;
      end else begin
         car_q <= car_d;
         on_q <= on_d;
         cnt_q <= cnt_d;
      end
   end
   assign carrier = car_q;
endmodule

// File: rtl/ir_code_sequencer.sv
// ir_code_sequencer: walks the ROM code table and emits each code as timed mark/space carrier bursts.
module ir_code_sequencer
   import ir_seq_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DUR_W = 16,
   parameter int TICK_DIV = 120,
   parameter int GAP_TICKS = 25000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start_in,
   input  logic                stop_in,
   input  logic                loop_forever_in,
   ir_code_sequencer_if.master rom,
   output logic                ir_out,
   output logic                busy_out,
   output logic                fail_out,
   output logic [7:0]          code_cnt
);
   localparam int PW = $clog2(TICK_DIV + 1);
   state_t             state_q, state_d;
   logic [ADDR_W:0]    addr_q, addr_d;
   logic [7:0]         half_q, half_d, pairs_q, pairs_d, cnt_q, cnt_d;
   logic [DUR_W-1:0]   dur_q, dur_d;
   logic [PW-1:0]      pre_q, pre_d;
   logic               rom_en_q, rom_en_d, busy_q, busy_d, fail_q, fail_d, start_q, start_d;
   logic               tick, expire, pair_done, mark_en;
   always_comb begin
      state_d = state_q;
      addr_d = addr_q;
      half_d = half_q;
      pairs_d = pairs_q;
      cnt_d = cnt_q;
      dur_d = dur_q;
      pre_d = pre_q;
      rom_en_d = 1'b0;
      start_d = start_in;
      pair_done = 1'b0;
      tick = pre_q == PW'(TICK_DIV - 1);
      expire = tick && dur_q == DUR_W'(1);
      if (state_q inside {MARK, SPACE, GAP}) begin
         pre_d = tick ? '0 : pre_q + 1'b1;
         dur_d = tick ? dur_q - 1'b1 : dur_q;
      end
      case (state_q)
         HDR: if (!rom_en_q) begin
            addr_d = addr_q + 1'b1;
            half_d = rom.rom_data[CARRIER_MSB:CARRIER_LSB];
            pairs_d = rom.rom_data[PAIRS_MSB:0];
            state_d = pairs_d == END_MARKER ? END : half_d == 8'd0 ? FAIL : MARK_RD;
            rom_en_d = state_d == MARK_RD;
         end
         MARK_RD: if (!rom_en_q) begin
            addr_d = addr_q + 1'b1;
            dur_d = DUR_W'(rom.rom_data);
            pre_d = '0;
            state_d = dur_d == '0 ? SPACE_RD : MARK;
            rom_en_d = dur_d == '0;
         end
         MARK: if (expire) begin
            state_d = SPACE_RD;
            rom_en_d = 1'b1;
         end
         SPACE_RD: if (!rom_en_q) begin
            addr_d = addr_q + 1'b1;
            dur_d = DUR_W'(rom.rom_data);
            pre_d = '0;
            state_d = SPACE;
            pair_done = dur_d == '0;
         end
         SPACE: pair_done = expire;
         GAP: if (expire) begin
            state_d = HDR;
            rom_en_d = 1'b1;
         end
         END: begin
            addr_d = '0;
            state_d = loop_forever_in ? HDR : IDLE;
            rom_en_d = loop_forever_in;
         end
         default: ;
      endcase
      if (pair_done) begin
         pairs_d = pairs_q - 8'd1;
         cnt_d = pairs_q == 8'd1 ? cnt_q + 8'd1 : cnt_q;
         state_d = pairs_q != 8'd1 ? MARK_RD : GAP_TICKS == 0 ? HDR : GAP;
         rom_en_d = state_d != GAP;
         dur_d = DUR_W'(GAP_TICKS);
         pre_d = '0;
      end
      if (start_in && !start_q) begin
         state_d = HDR;
         addr_d = '0;
         cnt_d = 8'd0;
         rom_en_d = 1'b1;
      end
      // A read past the last word faults instead of wrapping to address 0.
      if (rom_en_d && addr_d[ADDR_W]) begin
         state_d = FAIL;
         rom_en_d = 1'b0;
      end
      if (stop_in) begin
         state_d = state_q == FAIL ? FAIL : IDLE;
         addr_d = '0;
         cnt_d = cnt_q;
         rom_en_d = 1'b0;
      end
      busy_d = !(state_d inside {IDLE, FAIL});
      fail_d = state_d == FAIL;
      mark_en = state_d == MARK;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q <= '0;
         half_q <= 8'd0;
         pairs_q <= 8'd0;
         cnt_q <= 8'd0;
         dur_q <= '0;
         pre_q <= '0;
         rom_en_q <= 1'b0;
         busy_q <= 1'b0;
         fail_q <= 1'b0;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q <= addr_d;
         half_q <= half_d;
         pairs_q <= pairs_d;
         cnt_q <= cnt_d;
         dur_q <= dur_d;
         pre_q <= pre_d;
         rom_en_q <= rom_en_d;
         busy_q <= busy_d;
         fail_q <= fail_d;
         start_q <= start_d;
      end
   end
   ir_carrier_gen u_car (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (mark_en),
      .half_period (half_q),
      .carrier     (ir_out)
   );
   assign rom.rom_en = rom_en_q;
   assign rom.rom_addr = addr_q[ADDR_W-1:0];
   assign busy_out = busy_q;
   assign fail_out = fail_q;
   assign code_cnt = cnt_q;
endmodule

// File: tb/tb_ir_code_sequencer.sv
// tb_ir_code_sequencer: scoreboarded bench for ROM read order, ir_out waveform and status flags.
module tb_ir_code_sequencer;
   localparam int TD = 4;
   localparam int G = 2;
   typedef struct packed {logic ir; logic busy;} samp_t;
   logic clk = 1'b0, rst_n = 1'b0;
   logic start_in = 1'b0, stop_in = 1'b0, loop_in = 1'b0, start2 = 1'b0;
   logic ir_out, busy_out, fail_out, ir2, busy2, fail2;
   logic [7:0] code_cnt, cnt2;
   logic [15:0] mem [0:1023];
   logic [15:0] mem2 [0:7];
   int vectors = 0, miscompares = 0;
   int aq1 [$];
   int aq2 [$];
   samp_t wq [$];
   ir_code_sequencer_if #(.ADDR_W(10)) rif1 ();
   ir_code_sequencer_if #(.ADDR_W(3)) rif2 ();
   ir_code_sequencer #(.ADDR_W(10), .DUR_W(16), .TICK_DIV(TD), .GAP_TICKS(G)) dut (
      .clk(clk), .rst_n(rst_n), .start_in(start_in), .stop_in(stop_in), .loop_forever_in(loop_in),
      .rom(rif1), .ir_out(ir_out), .busy_out(busy_out), .fail_out(fail_out), .code_cnt(code_cnt));
   ir_code_sequencer #(.ADDR_W(3), .DUR_W(16), .TICK_DIV(TD), .GAP_TICKS(G)) dut2 (
      .clk(clk), .rst_n(rst_n), .start_in(start2), .stop_in(1'b0), .loop_forever_in(1'b0),
      .rom(rif2), .ir_out(ir2), .busy_out(busy2), .fail_out(fail2), .code_cnt(cnt2));
   always #5 clk = ~clk;
   always @(posedge clk) if (rif1.rom_en) rif1.rom_data <= mem[rif1.rom_addr];
   always @(posedge clk) if (rif2.rom_en) rif2.rom_data <= mem2[rif2.rom_addr];
   always @(negedge clk) begin
      int e;
      samp_t s;
      if (rst_n && rif1.rom_en === 1'b1) begin
         vectors++;
         if (aq1.size() == 0) begin
            miscompares++;
            $display("FAIL rd1_unexpected: read at addr %0d, required no read", rif1.rom_addr);
         end else begin
            e = aq1.pop_front();
            if (int'(rif1.rom_addr) != e) begin
               miscompares++;
               $display("FAIL rd1_addr: got %0d, required %0d", rif1.rom_addr, e);
            end
         end
      end
      if (rst_n && rif2.rom_en === 1'b1) begin
         vectors++;
         if (aq2.size() == 0) begin
            miscompares++;
            $display("FAIL rd2_unexpected: read at addr %0d, required no read", rif2.rom_addr);
         end else begin
            e = aq2.pop_front();
            if (int'(rif2.rom_addr) != e) begin
               miscompares++;
               $display("FAIL rd2_addr: got %0d, required %0d", rif2.rom_addr, e);
            end
         end
      end
      if (wq.size() > 0) begin
         s = wq.pop_front();
         vectors++;
         if (ir_out !== s.ir || busy_out !== s.busy) begin
            miscompares++;
            $display("FAIL wave: ir=%b busy=%b, required ir=%b busy=%b (%0d left)", ir_out, busy_out, s.ir, s.busy, wq.size());
         end
      end
   end
   function automatic void push_s(input logic ir, input logic b);
      wq.push_back('{ir: ir, busy: b});
   endfunction
   // Expected per-cycle ir_out/busy from the start edge: each ROM read costs 2 cycles.
   task automatic push_wave();
      int a = 0, half, np, n;
      forever begin
         repeat (2) push_s(1'b0, 1'b1);
         half = int'(mem[a][15:8]);
         np = int'(mem[a][7:0]);
         a++;
         if (np == 0) begin
            push_s(1'b0, 1'b1);
            push_s(1'b0, 1'b0);
            return;
         end
         for (int p = 0; p < np; p++) begin
            repeat (2) push_s(1'b0, 1'b1);
            n = int'(mem[a]) * TD;
            a++;
            for (int k = 0; k < n; k++) push_s(((k / half) % 2) == 0, 1'b1);
            repeat (2) push_s(1'b0, 1'b1);
            n = int'(mem[a]) * TD;
            a++;
            repeat (n) push_s(1'b0, 1'b1);
         end
         repeat (G * TD) push_s(1'b0, 1'b1);
      end
   endtask
   task automatic load_rom1();
      foreach (mem[i]) mem[i] = 16'h0;
      mem[0] = 16'h0302; mem[1] = 16'd5; mem[2] = 16'd3; mem[3] = 16'd2; mem[4] = 16'd0; mem[5] = 16'h0000;
   endtask
   task automatic push_reads(input int first, input int last);
      for (int i = first; i <= last; i++) aq1.push_back(i);
   endtask
   task automatic pulse_start(input bit wave);
      @(negedge clk) start_in = 1'b1;
      @(posedge clk);
      if (wave) push_wave();
      @(negedge clk) start_in = 1'b0;
   endtask
   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy_out !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (busy_out !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy_out, budget);
      end
   endtask
   task automatic test_reset();
      #12;
      vectors++;
      if ({ir_out, busy_out, fail_out, rif1.rom_en, code_cnt} !== 12'h0) begin
         miscompares++;
         $display("FAIL reset_outputs: ir=%b busy=%b fail=%b en=%b cnt=%0d, required all 0", ir_out, busy_out, fail_out, rif1.rom_en, code_cnt);
      end
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask
   task automatic test_single_code();
      load_rom1();
      push_reads(0, 5);
      pulse_start(1'b1);
      wait_idle(200);
      repeat (2) @(negedge clk);
      vectors++;
      if (code_cnt !== 8'd1 || fail_out !== 1'b0 || wq.size() != 0 || aq1.size() != 0) begin
         miscompares++;
         $display("FAIL single_status: cnt=%0d fail=%b wq=%0d aq=%0d, required 1 0 0 0", code_cnt, fail_out, wq.size(), aq1.size());
      end
   endtask
   task automatic test_loop_forever();
      int n = 0;
      load_rom1();
      loop_in = 1'b1;
      repeat (3) push_reads(0, 5);
      pulse_start(1'b0);
      while (code_cnt !== 8'd3 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      loop_in = 1'b0;
      vectors++;
      if (code_cnt !== 8'd3) begin
         miscompares++;
         $display("FAIL loop_cnt_timeout: cnt=%0d, required 3", code_cnt);
      end
      wait_idle(200);
      repeat (2) @(negedge clk);
      vectors++;
      if (code_cnt !== 8'd3 || aq1.size() != 0 || rif1.rom_addr !== 10'd0) begin
         miscompares++;
         $display("FAIL loop_end: cnt=%0d aq=%0d addr=%0d, required 3 0 0", code_cnt, aq1.size(), rif1.rom_addr);
      end
   endtask
   task automatic test_carrier_fault();
      foreach (mem[i]) mem[i] = 16'h0;
      mem[0] = 16'h0001;
      aq1.push_back(0);
      pulse_start(1'b0);
      @(negedge clk);
      vectors++;
      if (fail_out !== 1'b0 || busy_out !== 1'b1) begin
         miscompares++;
         $display("FAIL fault_pre: fail=%b busy=%b, required 0 1", fail_out, busy_out);
      end
      @(negedge clk);
      vectors++;
      if (fail_out !== 1'b1 || busy_out !== 1'b0 || ir_out !== 1'b0) begin
         miscompares++;
         $display("FAIL fault_flag: fail=%b busy=%b ir=%b, required 1 0 0", fail_out, busy_out, ir_out);
      end
      repeat (5) @(negedge clk);
      vectors++;
      if (fail_out !== 1'b1) begin
         miscompares++;
         $display("FAIL fault_sticky: fail=%b, required 1", fail_out);
      end
      load_rom1();
      push_reads(0, 5);
      pulse_start(1'b1);
      vectors++;
      if (fail_out !== 1'b0 || code_cnt !== 8'd0) begin
         miscompares++;
         $display("FAIL fault_clear: fail=%b cnt=%0d, required 0 0", fail_out, code_cnt);
      end
      wait_idle(200);
      repeat (2) @(negedge clk);
   endtask
   task automatic test_stop_abort();
      int n = 0;
      foreach (mem[i]) mem[i] = 16'h0;
      mem[0] = 16'h0301; mem[1] = 16'd2; mem[2] = 16'd1;
      mem[3] = 16'h0201; mem[4] = 16'd3; mem[5] = 16'd1; mem[6] = 16'h0000;
      push_reads(0, 4);
      pulse_start(1'b0);
      while (!(code_cnt === 8'd1 && ir_out === 1'b1) && n < 500) begin
         @(negedge clk);
         n++;
      end
      stop_in = 1'b1;
      @(negedge clk);
      vectors++;
      if (ir_out !== 1'b0 || busy_out !== 1'b0 || code_cnt !== 8'd1 || rif1.rom_en !== 1'b0) begin
         miscompares++;
         $display("FAIL stop_abort: ir=%b busy=%b cnt=%0d en=%b, required 0 0 1 0", ir_out, busy_out, code_cnt, rif1.rom_en);
      end
      repeat (5) @(negedge clk);
      stop_in = 1'b0;
      vectors++;
      if (code_cnt !== 8'd1 || aq1.size() != 0) begin
         miscompares++;
         $display("FAIL stop_hold: cnt=%0d aq=%0d, required 1 0", code_cnt, aq1.size());
      end
      push_reads(0, 6);
      pulse_start(1'b0);
      vectors++;
      if (rif1.rom_en !== 1'b1 || rif1.rom_addr !== 10'd0 || code_cnt !== 8'd0) begin
         miscompares++;
         $display("FAIL stop_restart: en=%b addr=%0d cnt=%0d, required 1 0 0", rif1.rom_en, rif1.rom_addr, code_cnt);
      end
      wait_idle(300);
      repeat (2) @(negedge clk);
      vectors++;
      if (code_cnt !== 8'd2 || aq1.size() != 0) begin
         miscompares++;
         $display("FAIL stop_rerun: cnt=%0d aq=%0d, required 2 0", code_cnt, aq1.size());
      end
   endtask
   task automatic test_addr_overflow();
      int n = 0;
      mem2[0] = 16'h0103;
      for (int i = 1; i < 7; i++) mem2[i] = 16'd1;
      mem2[7] = 16'h0101;
      for (int i = 0; i < 8; i++) aq2.push_back(i);
      @(negedge clk) start2 = 1'b1;
      @(negedge clk) start2 = 1'b0;
      while (fail2 !== 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      repeat (10) @(negedge clk);
      vectors++;
      if (fail2 !== 1'b1 || busy2 !== 1'b0 || ir2 !== 1'b0 || aq2.size() != 0 || rif2.rom_en !== 1'b0) begin
         miscompares++;
         $display("FAIL overflow: fail=%b busy=%b ir=%b reads_left=%0d en=%b, required 1 0 0 0 0", fail2, busy2, ir2, aq2.size(), rif2.rom_en);
      end
   endtask
   task automatic test_async_reset();
      load_rom1();
      push_reads(0, 2);
      pulse_start(1'b0);
      repeat (29) @(negedge clk);
      vectors++;
      if (ir_out !== 1'b0 || busy_out !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_space: ir=%b busy=%b, required 0 1", ir_out, busy_out);
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({ir_out, busy_out, fail_out, rif1.rom_en, rif1.rom_addr, code_cnt} !== 22'h0) begin
         miscompares++;
         $display("FAIL async_reset: ir=%b busy=%b fail=%b en=%b addr=%0d cnt=%0d, required all 0", ir_out, busy_out, fail_out, rif1.rom_en, rif1.rom_addr, code_cnt);
      end
      @(negedge clk) rst_n = 1'b1;
      repeat (20) @(negedge clk);
      vectors++;
      if (busy_out !== 1'b0 || ir_out !== 1'b0 || fail_out !== 1'b0 || aq1.size() != 0) begin
         miscompares++;
         $display("FAIL post_reset_idle: busy=%b ir=%b fail=%b aq=%0d, required 0 0 0 0", busy_out, ir_out, fail_out, aq1.size());
      end
   endtask
   initial begin
      test_reset();
      test_single_code();
      test_loop_forever();
      test_carrier_fault();
      test_stop_abort();
      test_addr_overflow();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
